// File: rtl/pkt_receiver_if.sv
// Bus and consumer-side signals of the packet receiver, grouped so the
// receiver and its environment connect through a single port.
interface pkt_receiver_if;
    logic        bus_rx;
    logic        bus_tx;
    logic        bus_tx_en;
    logic [63:0] rx_data;
    logic [3:0]  rx_src;
    logic        rx_valid;
    logic        rx_ready;
    logic        crc_err;
    logic        frame_err;
    logic        overrun;

    modport master (
        input  bus_rx, rx_ready,
        output bus_tx, bus_tx_en, rx_data, rx_src, rx_valid,
               crc_err, frame_err, overrun
    );

    modport slave (
        output bus_rx, rx_ready,
        input  bus_tx, bus_tx_en, rx_data, rx_src, rx_valid,
               crc_err, frame_err, overrun
    );
endinterface

// File: rtl/pkt_receiver.sv
// Serial 80-bit frame receiver: shifts a frame in LSB first, evaluates it on
// the turnaround edge, and acknowledges good frames for two cycles.
module pkt_receiver (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           enable,
    input  logic [3:0]     addr,
    input  logic [3:0]     crc,
    pkt_receiver_if.master bus
);

    typedef enum logic [2:0] {IDLE, RECV, TURN, ACK, HOLD} state_e;

    state_e      state_q, state_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [79:0] frame_q, frame_d;
    logic [63:0] rx_data_q, rx_data_d;
    logic [3:0]  rx_src_q, rx_src_d;
    logic        rx_valid_q, rx_valid_d;
    logic        bus_tx_q, bus_tx_d;
    logic        bus_tx_en_q, bus_tx_en_d;
    logic        crc_err_q, crc_err_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic dest_match, framing_ok, crc_ok;

    // The shift register fills from the top, so after 80 bits the start bit sits at [0].
    assign dest_match = (frame_q[8:5] == addr);
    assign framing_ok = (frame_q[10:9] == 2'b11) && frame_q[79] && !frame_q[0];
    assign crc_ok     = (frame_q[78:75] == crc);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        rx_data_d   = rx_data_q;
        rx_src_d    = rx_src_q;
        rx_valid_d  = rx_valid_q && !bus.rx_ready;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // An X/Z level compares unknown and does not start a frame.
                if (enable && (bus.bus_rx == 1'b0)) begin
                    frame_d   = {bus.bus_rx, frame_q[79:1]};
                    bit_cnt_d = 7'd1;
                    state_d   = RECV;
                end
            end
            RECV: begin
                frame_d = {bus.bus_rx, frame_q[79:1]};
                if (bit_cnt_q == 7'd79) begin
                    bit_cnt_d = 7'd0;
                    state_d   = TURN;
                end else begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
            TURN: begin
                state_d = HOLD;
                if (dest_match) begin
                    if (!framing_ok) begin
                        frame_err_d = 1'b1;
                    end else if (!crc_ok) begin
                        crc_err_d = 1'b1;
                    end else if (rx_valid_q && !bus.rx_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        rx_data_d  = frame_q[74:11];
                        rx_src_d   = frame_q[4:1];
                        rx_valid_d = 1'b1;
                        state_d    = ACK;
                    end
                end
            end
            ACK, HOLD: begin
                // bit_cnt is reused to time the two-cycle acknowledge window.
                if (bit_cnt_q == 7'd1) begin
                    bit_cnt_d = 7'd0;
                    state_d   = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
            default: begin
                bit_cnt_d = 7'd0;
                state_d   = IDLE;
            end
        endcase

        bus_tx_en_d = (state_d == ACK);
        bus_tx_d    = (state_d == ACK);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 7'd0;
            frame_q     <= 80'd0;
            rx_data_q   <= 64'd0;
            rx_src_q    <= 4'd0;
            rx_valid_q  <= 1'b0;
            bus_tx_q    <= 1'b0;
            bus_tx_en_q <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            rx_data_q   <= rx_data_d;
            rx_src_q    <= rx_src_d;
            rx_valid_q  <= rx_valid_d;
            bus_tx_q    <= bus_tx_d;
            bus_tx_en_q <= bus_tx_en_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.bus_tx    = bus_tx_q;
    assign bus.bus_tx_en = bus_tx_en_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_src    = rx_src_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_pkt_receiver.sv
// Directed bench for pkt_receiver: drives serial frames on falling edges and
// checks the acknowledge window, status pulses and received payloads.
module tb_pkt_receiver;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b1;
    logic [3:0] addr    = 4'd5;
    logic [3:0] crc     = 4'hA;

    pkt_receiver_if bus ();

    pkt_receiver dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .addr    (addr),
        .crc     (crc),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // Snapshots taken after E80, E81 and E82.
    logic [2:0]  en_s, tx_s, ce_s, fe_s, ov_s, rv_s;
    logic [63:0] data_s;
    logic [3:0]  src_s;

    localparam logic [63:0] DATA1 = 64'hDEADBEEF_01234567;
    localparam logic [63:0] DATA2 = 64'h01234567_89ABCDEF;
    localparam logic [63:0] DATA3 = 64'h5555AAAA_F00DCAFE;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] make_frame(input logic [3:0] src, input logic [3:0] dest,
                                               input logic [1:0] size, input logic [63:0] data,
                                               input logic [3:0] fcrc, input logic end_bit);
        logic [79:0] f;
        f[0]     = 1'b0;
        f[4:1]   = src;
        f[8:5]   = dest;
        f[10:9]  = size;
        f[74:11] = data;
        f[78:75] = fcrc;
        f[79]    = end_bit;
        return f;
    endfunction

    task automatic sample(input int k);
        en_s[k] = bus.bus_tx_en;
        tx_s[k] = bus.bus_tx;
        ce_s[k] = bus.crc_err;
        fe_s[k] = bus.frame_err;
        ov_s[k] = bus.overrun;
        rv_s[k] = bus.rx_valid;
        if (k == 0) begin
            data_s = bus.rx_data;
            src_s  = bus.rx_src;
        end
    endtask

    // Bit i is sampled at edge Ei; the turnaround level 0 is held through E82.
    task automatic run_frame(input logic [79:0] f, input logic rdy);
        for (int i = 0; i < 80; i++) begin
            bus.bus_rx = f[i];
            @(negedge clock);
        end
        bus.bus_rx   = 1'b0;
        bus.rx_ready = rdy;
        @(negedge clock);
        sample(0);
        bus.rx_ready = 1'b0;
        @(negedge clock);
        sample(1);
        @(negedge clock);
        sample(2);
    endtask

    task automatic expect_ack(input string tag, input logic [63:0] data, input logic [3:0] src);
        check({tag, "_en"}, {61'd0, en_s}, 64'b011);
        check({tag, "_tx"}, {61'd0, tx_s}, 64'b011);
        check({tag, "_valid"}, rv_s[0], 1'b1);
        check({tag, "_data"}, data_s, data);
        check({tag, "_src"}, src_s, src);
        check({tag, "_pulses"}, {61'd0, ce_s | fe_s | ov_s}, 64'd0);
    endtask

    task automatic expect_noack(input string tag, input logic ce, input logic fe, input logic ov);
        check({tag, "_en"}, {61'd0, en_s}, 64'd0);
        check({tag, "_tx"}, {61'd0, tx_s}, 64'd0);
        check({tag, "_crc_err"}, {61'd0, ce_s}, {63'd0, ce});
        check({tag, "_frame_err"}, {61'd0, fe_s}, {63'd0, fe});
        check({tag, "_overrun"}, {61'd0, ov_s}, {63'd0, ov});
    endtask

    task automatic consume(input string tag);
        bus.bus_rx   = 1'b1;
        bus.rx_ready = 1'b1;
        @(negedge clock);
        bus.rx_ready = 1'b0;
        check({tag, "_consumed"}, bus.rx_valid, 1'b0);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        bus.bus_rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    logic [79:0] f_good1, f_good2, f_good3;

    initial begin
        bus.bus_rx   = 1'b1;
        bus.rx_ready = 1'b0;
        f_good1 = make_frame(4'd3, 4'd5, 2'b11, DATA1, 4'hA, 1'b1);
        f_good2 = make_frame(4'd7, 4'd5, 2'b11, DATA2, 4'hA, 1'b1);
        f_good3 = make_frame(4'hC, 4'd5, 2'b11, DATA3, 4'hA, 1'b1);

        repeat (3) @(negedge clock);
        check("rst_en", bus.bus_tx_en, 1'b0);
        check("rst_tx", bus.bus_tx, 1'b0);
        check("rst_valid", bus.rx_valid, 1'b0);
        check("rst_data", bus.rx_data, 64'd0);
        check("rst_src", bus.rx_src, 4'd0);
        check("rst_pulses", {bus.crc_err, bus.frame_err, bus.overrun}, 3'd0);
        reset_n = 1'b1;
        idle(2);

        // Good frame to own address.
        run_frame(f_good1, 1'b0);
        expect_ack("good", DATA1, 4'd3);
        consume("good");

        // CRC field mismatch.
        run_frame(make_frame(4'd3, 4'd5, 2'b11, DATA1, 4'h6, 1'b1), 1'b0);
        expect_noack("crc", 1'b1, 1'b0, 1'b0);
        check("crc_valid", {61'd0, rv_s}, 64'd0);
        idle(2);

        // Frame for another node, then an immediate frame for us at E83.
        run_frame(make_frame(4'd3, 4'd9, 2'b11, DATA1, 4'hA, 1'b1), 1'b0);
        expect_noack("other", 1'b0, 1'b0, 1'b0);
        run_frame(f_good2, 1'b0);
        expect_ack("b2b", DATA2, 4'd7);
        consume("b2b");

        // Back to back with no consumer: second overruns, third reloads with ready at E80.
        run_frame(f_good1, 1'b0);
        expect_ack("hold1", DATA1, 4'd3);
        run_frame(f_good2, 1'b0);
        expect_noack("ovr", 1'b0, 1'b0, 1'b1);
        check("ovr_data_kept", data_s, DATA1);
        check("ovr_src_kept", src_s, 4'd3);
        run_frame(f_good3, 1'b1);
        expect_ack("reload", DATA3, 4'hC);

        // Reset in the middle of a frame while a payload is still held.
        for (int i = 0; i < 40; i++) begin
            bus.bus_rx = f_good1[i];
            @(negedge clock);
        end
        reset_n = 1'b0;
        #1;
        check("midrst_en", bus.bus_tx_en, 1'b0);
        check("midrst_valid", bus.rx_valid, 1'b0);
        check("midrst_data", bus.rx_data, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(3);
        run_frame(f_good1, 1'b0);
        expect_ack("postrst", DATA1, 4'd3);
        consume("postrst");

        // Framing errors to own address.
        run_frame(make_frame(4'd3, 4'd5, 2'b11, DATA2, 4'hA, 1'b0), 1'b0);
        expect_noack("noend", 1'b0, 1'b1, 1'b0);
        check("noend_valid", rv_s[0], 1'b0);
        check("noend_data", bus.rx_data, DATA1);
        idle(2);
        run_frame(make_frame(4'd3, 4'd5, 2'b01, DATA2, 4'hA, 1'b1), 1'b0);
        expect_noack("size", 1'b0, 1'b1, 1'b0);
        check("size_data", bus.rx_data, DATA1);
        idle(2);

        // Receiver disabled: a valid frame is ignored.
        enable = 1'b0;
        run_frame(f_good2, 1'b0);
        expect_noack("disabled", 1'b0, 1'b0, 1'b0);
        check("disabled_valid", rv_s[0], 1'b0);
        bus.bus_rx = 1'b1;
        enable     = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pkt_receiver.md
PKT_RECEIVER -- requirements
Module: pkt_receiver

Interface
REQ-001 Parameters SHALL be none; all packet widths are fixed by the bus protocol.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  1 = listen for frames; sampled only in IDLE.
REQ-005 addr  input  4  this node's address.
REQ-006 crc  input  4  expected CRC field value.
REQ-007 bus_rx  input  1  sampled serial bus level.
REQ-008 bus_tx  output  1  value driven on bus when bus_tx_en=1.
REQ-009 bus_tx_en  output  1  tri-state enable; the integrating level builds the bus driver.
REQ-010 rx_data  output  64  payload of last accepted frame.
REQ-011 rx_src  output  4  source address of last accepted frame.
REQ-012 rx_valid  output  1  rx_data/rx_src hold an unconsumed frame.
REQ-013 rx_ready  input  1  consumer accepts frame when rx_valid&&rx_ready at a rising edge.
REQ-014 crc_err, frame_err, overrun  output  1 each  one-cycle status pulses.

Function
REQ-015 Frame SHALL be 80 bits, LSB first: [0] start=0, [4:1] src, [8:5] dest, [10:9] size (must be 2'b11), [74:11] data, [78:75] crc, [79] end=1.
REQ-016 States SHALL be IDLE, RECV, TURN, ACK, HOLD.
REQ-017 IDLE: edge E0 with enable=1 and bus_rx==1'b0 SHALL store bit 0, set bit_cnt=1, go RECV; X/Z or 1 SHALL not start a frame.
REQ-018 RECV: edges E1..E79 SHALL store bus_rx into bit[bit_cnt] and increment; at E79 go TURN.
REQ-019 TURN: at E80 the bus level (sender turnaround 0) SHALL be ignored and the frame evaluated.
REQ-020 Frame is "good" iff dest==addr, crc field==crc, size==2'b11, end==1.
REQ-021 dest!=addr: no status pulse, no ack, go HOLD.
REQ-022 dest==addr with end!=1 or size!=2'b11: frame_err pulse, no ack, go HOLD.
REQ-023 dest==addr, framing OK, crc mismatch: crc_err pulse, no ack, go HOLD.
REQ-024 Good frame with rx_valid=0, or rx_valid&&rx_ready at E80: load rx_data, rx_src, set rx_valid=1, go ACK.
REQ-025 Good frame with rx_valid=1 and rx_ready=0 at E80: overrun pulse, outputs unchanged, no ack, go HOLD.
REQ-026 ACK: bus_tx_en=1, bus_tx=1 for exactly the two cycles following E80; at E82 release bus_tx_en=0, go IDLE.
REQ-027 HOLD: bus_tx_en=0 for two cycles (ack window), ignoring bus_rx; at E82 go IDLE.
REQ-028 Status pulses SHALL be high for the single cycle following E80.
REQ-029 rx_valid SHALL clear at any edge with rx_valid&&rx_ready except when reloaded per REQ-024.
REQ-030 Earliest next start bit SHALL be accepted at E83.
REQ-031 bus_tx_en SHALL be 1 only in ACK; bus_tx SHALL be 0 outside ACK.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, bit_cnt=0, bus_tx_en=0, bus_tx=0, rx_valid=0, rx_data=0, rx_src=0, all status pulses 0.
REQ-034 Reset asserted mid-RECV or mid-ACK SHALL discard the partial frame and release the bus in the same cycle; after release the block waits for a fresh start bit.

Verification
REQ-035 addr=5, crc=4'hA, frame src=3 dest=5 data=64'hDEADBEEF_01234567 crc=A -> rx_valid=1, rx_data/rx_src match after E80, bus_tx_en=1 with bus_tx=1 for exactly 2 cycles, then IDLE.
REQ-036 Same frame with crc field=4'h6 -> crc_err one-cycle pulse, rx_valid stays 0, bus_tx_en never 1.
REQ-037 Frame dest=9 while addr=5, bus held 0 during E81-E82 -> no pulses, no false start, IDLE at E83; immediate second frame at E83 to dest=5 accepted.
REQ-038 Two good frames back to back, rx_ready=0 throughout -> first held, overrun pulse on second, no second ack; repeat with rx_ready=1 at second E80 -> second frame loaded and acked.
REQ-039 reset_n pulsed low at E40 -> bus_tx_en=0, state IDLE; subsequent full good frame received and acked normally.
REQ-040 Frame with bit 79=0 or size=2'b01 to own address -> frame_err pulse, no ack, no data update.
